// File: rtl/load_store_unit_if.sv
// Request/response bundle between the RV32I execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_fault
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32I loads/stores into accesses on a
// word-only RAM port. Sub-word stores are read-modify-write because the RAM has
// no byte enables. Illegal funct3, misaligned, out-of-range and RAM seg-fault
// accesses are reported through resp_fault.
// Optional macro LSU_FAULT_ADDR_EN adds a fault_addr output that records the
// byte address of the most recent faulted request.
module load_store_unit #(
   parameter int ADDR_W       = 11,
   parameter int FAULT_ON_OOR = 1
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   bus,
`ifdef LSU_FAULT_ADDR_EN
   output logic [31:0]        fault_addr,
`endif
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [31:0]        ram_din,
   output logic               ram_write_en,
   input  logic [31:0]        ram_dout,
   input  logic               ram_seg_fault
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ACCESS     = 3'd1,
      ST_CAPTURE    = 3'd2,
      ST_MERGE      = 3'd3,
      ST_RESP       = 3'd4,
      ST_FAULT_RESP = 3'd5
   } state_t;

   state_t             state_r, state_nx_s;
   logic               we_r;
   logic [2:0]         funct3_r;
   logic [1:0]         off_r;
   logic               seg_r;
   logic               resp_valid_r, resp_fault_r;
   logic [31:0]        resp_rdata_r;
   logic [ADDR_W-1:0]  ram_addr_r;
   logic [31:0]        ram_din_r;
   logic               ram_write_en_r;
   logic               accept_s, req_bad_s, seg_any_s;

   function automatic logic funct3_illegal_f(input logic we, input logic [2:0] f3);
      logic bad;
      if (we) bad = (f3 > 3'b010);
      else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      return bad;
   endfunction

   function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3[1:0])
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] load_extend_f(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shifted = word >> {off, 3'b000};
      b       = shifted[7:0];
      h       = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'h00_0000, b};
         3'b101:  r = {16'h0000, h};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_f(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word, input logic [15:0] wdata);
      logic [31:0] mask, ins;
      case (f3)
         3'b000: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            ins  = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
         end
         3'b001: begin
            mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            ins  = off[1] ? {wdata, 16'h0000} : {16'h0000, wdata};
         end
         default: begin
            mask = 32'h0000_0000;
            ins  = 32'h0000_0000;
         end
      endcase
      return (word & ~mask) | ins;
   endfunction

   assign bus.req_ready  = (state_r == ST_IDLE) && !rst;
   assign accept_s       = bus.req_valid && bus.req_ready;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_fault = resp_fault_r;
   assign bus.resp_rdata = resp_rdata_r;
   assign ram_addr       = ram_addr_r;
   assign ram_write_en   = ram_write_en_r;

   // Classify the incoming request as faulting before any RAM cycle is issued.
   always_comb begin
      req_bad_s = funct3_illegal_f(bus.req_we, bus.req_funct3) ||
                  misaligned_f(bus.req_funct3, bus.req_addr[1:0]);
      if ((FAULT_ON_OOR != 0) && ((bus.req_addr >> (ADDR_W + 2)) != 32'd0)) begin
         req_bad_s = 1'b1;
      end else begin
         req_bad_s = req_bad_s;
      end
   end

   // Seg faults are only meaningful while the RAM is being addressed.
   always_comb begin
      if ((state_r == ST_ACCESS) || (state_r == ST_MERGE)) seg_any_s = seg_r | ram_seg_fault;
      else                                                 seg_any_s = seg_r;
   end

   // The merged word depends on read data that only arrives in MERGE, so the
   // write data is steered combinationally during that one cycle.
   always_comb begin
      if (state_r == ST_MERGE) ram_din = merge_f(funct3_r, off_r, ram_dout, ram_din_r[15:0]);
      else                     ram_din = ram_din_r;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx_s;
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nx_s = req_bad_s ? ST_FAULT_RESP : ST_ACCESS;
            else          state_nx_s = ST_IDLE;
         end
         ST_ACCESS: begin
            if (we_r && (funct3_r == 3'b010)) state_nx_s = ST_RESP;
            else if (we_r)                    state_nx_s = ST_MERGE;
            else                              state_nx_s = ST_CAPTURE;
         end
         ST_CAPTURE:    state_nx_s = ST_RESP;
         ST_MERGE:      state_nx_s = ST_RESP;
         ST_RESP:       state_nx_s = ST_IDLE;
         ST_FAULT_RESP: state_nx_s = ST_IDLE;
         default:       state_nx_s = ST_IDLE;
      endcase
   end

   // Request latch, RAM port registers and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_r           <= 1'b0;
         funct3_r       <= 3'b000;
         off_r          <= 2'b00;
         seg_r          <= 1'b0;
         ram_addr_r     <= '0;
         ram_din_r      <= 32'h0000_0000;
         ram_write_en_r <= 1'b0;
         resp_valid_r   <= 1'b0;
         resp_fault_r   <= 1'b0;
         resp_rdata_r   <= 32'h0000_0000;
      end else begin
         if (accept_s) begin
            we_r       <= bus.req_we;
            funct3_r   <= bus.req_funct3;
            off_r      <= bus.req_addr[1:0];
            seg_r      <= 1'b0;
            ram_addr_r <= bus.req_addr[ADDR_W+1:2];
            ram_din_r  <= bus.req_wdata;
         end else begin
            seg_r <= seg_any_s;
         end
         // A sub-word store whose read already faulted does not write back.
         ram_write_en_r <= ((state_nx_s == ST_ACCESS) && bus.req_we && (bus.req_funct3 == 3'b010)) ||
                           ((state_nx_s == ST_MERGE) && !ram_seg_fault);
         resp_valid_r   <= (state_nx_s == ST_RESP) || (state_nx_s == ST_FAULT_RESP);
         resp_fault_r   <= (state_nx_s == ST_FAULT_RESP) || ((state_nx_s == ST_RESP) && seg_any_s);
         if (state_r == ST_CAPTURE) begin
            resp_rdata_r <= seg_any_s ? 32'h0000_0000 : load_extend_f(funct3_r, off_r, ram_dout);
         end else if ((state_nx_s == ST_RESP) || (state_nx_s == ST_FAULT_RESP)) begin
            resp_rdata_r <= 32'h0000_0000;
         end else begin
            resp_rdata_r <= resp_rdata_r;
         end
      end
   end

`ifdef LSU_FAULT_ADDR_EN
   logic [31:0] addr_r, fault_addr_r;
   assign fault_addr = fault_addr_r;

   // Keep the full request address and capture it whenever a fault is reported.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r       <= 32'h0000_0000;
         fault_addr_r <= 32'h0000_0000;
      end else begin
         if (accept_s) addr_r <= bus.req_addr;
         else          addr_r <= addr_r;
         if (resp_valid_r && resp_fault_r) fault_addr_r <= addr_r;
         else                              fault_addr_r <= fault_addr_r;
      end
   end
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I execute stage and the `RAM` block, directly upstream of RAM.
- Translates byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on RAM's 11-bit word port.
- Performs sign/zero extension on loads.
- RAM has no byte enables, so SB/SH are done as read-modify-write.
- Flags misaligned, out-of-range, illegal-funct3 and RAM seg-fault accesses.

Parameters:
- ADDR_W, 11, RAM word-address width; addressable bytes = 4*2^ADDR_W.
- FAULT_ON_OOR, 1, when 1, req_addr bits [31:ADDR_W+2] nonzero raise a fault with no RAM access.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and not in reset; transfer when valid&&ready.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes used for B/H.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid.
- ram_addr  out  ADDR_W  word index = latched req_addr[ADDR_W+1:2].
- ram_din  out  32  write data to RAM.
- ram_write_en  out  1  RAM write strobe.
- ram_dout  in  32  RAM read data, valid the cycle after ram_addr is presented.
- ram_seg_fault  in  1  RAM access error, sampled in ACCESS and MERGE.

Behaviour:
- Reset (async): state=IDLE. resp_valid, resp_fault, ram_write_en = 0. resp_rdata, ram_addr, ram_din, latched request = 0. req_ready=0 while rst is high.
- IDLE: on valid&&ready, latch we/funct3/addr/wdata.
  - Illegal funct3 (load 011/110/111; store anything >010), misalignment (H with addr[0]=1; W with addr[1:0]≠0) or out-of-range → state FAULT_RESP, no RAM cycle.
  - Otherwise → ACCESS.
- ACCESS: ram_addr driven from the latch.
  - SW: ram_write_en=1, ram_din=wdata → RESP.
  - Loads and SB/SH: read (ram_write_en=0) → CAPTURE for loads, MERGE for SB/SH.
- CAPTURE: select byte addr[1:0] or halfword addr[1]; sign-extend (B/H) or zero-extend (BU/HU); pass word (W) into resp_rdata → RESP.
- MERGE: ram_din = ram_dout with the target byte/halfword replaced by wdata[7:0]/[15:0]; ram_write_en=1; ram_addr held → RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_fault = any seg fault sampled during the operation → IDLE.
- FAULT_RESP: resp_valid=1, resp_fault=1, resp_rdata=0 → IDLE.
- Latency from accept edge to resp_valid high: SW 2 cycles; loads, SB, SH 3 cycles; fault 1 cycle.
- ram_write_en is never high outside ACCESS or MERGE and never high for a faulted request.
- req_ready is low from accept until the cycle after RESP/FAULT_RESP; back-to-back requests need no idle cycle beyond that.
- Reset mid-operation: abort immediately; no further RAM write and no response. Any write already strobed stands.

Optional Feature:
- Macro LSU_FAULT_ADDR_EN.
- Defined: adds output fault_addr [31:0], reset 0. It loads the latched req_addr on every cycle resp_valid&&resp_fault, and holds otherwise.
- Undefined: port and register absent; no other behaviour change.

Test Plan:
- SW addr 0x014 data 0xDEADBEEF, then LW 0x014 → ram_write_en pulse with ram_addr=5; load resp_rdata=0xDEADBEEF, fault=0, 3 cycles after accept.
- Word 0x80FF7F01 at 0x020; LB 0x021 → 0x0000007F; LB 0x022 → 0xFFFFFFFF; LBU 0x023 → 0x00000080; LH 0x022 → 0xFFFF80FF; LHU 0x022 → 0x000080FF.
- Word 0x11223344 at 0x030; SB 0x031 data 0xAA → RAM word 0x1122AA44; SH 0x032 data 0xBEEF → 0xBEEFAA44; each takes one read cycle then one write cycle.
- LW 0x006, SH 0x001, load funct3=011 → resp_valid+resp_fault after 1 cycle, resp_rdata=0, ram_write_en never asserted.
- ram_seg_fault forced high during ACCESS of LW 0x100 → resp_fault=1 on the response.
- rst asserted in MERGE of SB → no ram_write_en after rst rises, no resp_valid; req_ready=1 after rst falls.
